// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, 4-bit instruction register,
// bypass and IDCODE data registers, and boundary-scan chain control strobes.
// TDO and TDO_En are registered on the falling edge of TCK.
// Define TAP_IDCODE_EN to include the IDCODE instruction and its 32-bit register.
// Without it, 0010 decodes as BYPASS and the reset/TLR instruction is BYPASS.
module tap_controller #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic       TCK,
  input  logic       Reset,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       BSC_TDO,
  output logic       TDO,
  output logic       TDO_En,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Mode,
  output logic [3:0] TapState
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [3:0] IR_EXTEST  = 4'b0000;
  localparam logic [3:0] IR_SAMPLE  = 4'b0001;
  localparam logic [3:0] IR_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0] IR_IDCODE  = 4'b0010;
  localparam logic [3:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [3:0] IR_RESET   = IR_BYPASS;
`endif

  tap_state_e state_q, state_d;
  logic [3:0] ir_shift_q, ir_shift_d;
  logic [3:0] ir_q, ir_d;
  logic       bypass_q, bypass_d;
  logic       tdo_q, tdo_d;
  logic       tdo_en_q, tdo_en_d;
  logic       bsc_sel;
  logic       dr_tdo;

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;
`else
  // The ID value has no register to load into in this build.
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VALUE;
`endif

  // TAP next-state logic, one TMS-driven transition per rising TCK
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Instruction shift/update and bypass register updates; TLR behaves like reset
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    bypass_d   = bypass_q;
    case (state_q)
      CAP_IR:  ir_shift_d = IR_CAPTURE;
      SH_IR:   ir_shift_d = {TDI, ir_shift_q[3:1]};
      UPD_IR:  ir_d       = ir_shift_q;
      CAP_DR:  bypass_d   = 1'b0;
      SH_DR:   bypass_d   = TDI;
      default: ;
    endcase
    if (state_d == TLR) begin
      ir_d       = IR_RESET;
      ir_shift_d = IR_CAPTURE;
    end
  end

  // Rising-edge state, instruction and bypass registers with synchronous reset
  always_ff @(posedge TCK) begin
    if (Reset) begin
      state_q    <= TLR;
      ir_shift_q <= IR_CAPTURE;
      ir_q       <= IR_RESET;
      bypass_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
      ir_q       <= ir_d;
      bypass_q   <= bypass_d;
    end
  end

`ifdef TAP_IDCODE_EN
  // IDCODE register captures the device ID and shifts it out LSB first
  always_comb begin
    idcode_d = idcode_q;
    if (state_q == CAP_DR)     idcode_d = IDCODE_VALUE;
    else if (state_q == SH_DR) idcode_d = {TDI, idcode_q[31:1]};
  end

  // IDCODE register flops
  always_ff @(posedge TCK) begin
    if (Reset) idcode_q <= IDCODE_VALUE;
    else       idcode_q <= idcode_d;
  end
`endif

  // Instruction decode: which data register sits between TDI and TDO
  always_comb begin
    bsc_sel = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
`ifdef TAP_IDCODE_EN
    dr_tdo  = (ir_q == IR_IDCODE) ? idcode_q[0] : bypass_q;
`else
    dr_tdo  = bypass_q;
`endif
  end

  // Serial output select; TDO is forced low whenever it is not enabled
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    case (state_q)
      SH_IR: begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end
      SH_DR: begin
        tdo_d    = bsc_sel ? BSC_TDO : dr_tdo;
        tdo_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  // TDO launches on the falling edge; a reset edge always leaves TLR here
  always_ff @(negedge TCK) begin
    tdo_q    <= tdo_d;
    tdo_en_q <= tdo_en_d;
  end

  assign TapState = state_q;
  assign TDO      = tdo_q;
  assign TDO_En   = tdo_en_q;
  assign Mode     = (ir_q == IR_EXTEST);
  assign ShiftDR  = (state_q == SH_DR) && bsc_sel;
  assign ClockDR  = ~TCK && ((state_q == CAP_DR) || (state_q == SH_DR)) && bsc_sel;
  assign UpdateDR = ~TCK && (state_q == UPD_DR) && bsc_sel;

endmodule

// File: tb/tb_tap_controller.sv
// Directed testbench for tap_controller with a TDO scoreboard queue.
// Honours TAP_IDCODE_EN to pick the expected IDCODE-scan result.
module tb_tap_controller;

  localparam logic [31:0] ID_VALUE = 32'h1000_0001;

  logic       TCK = 1'b0;
  logic       Reset = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       BSC_TDO = 1'b0;
  logic       TDO, TDO_En, ShiftDR, ClockDR, UpdateDR, Mode;
  logic [3:0] TapState;

  int assertCount = 0;
  int failCount = 0;
  int clockDrPulses = 0;
  int updateDrPulses = 0;
  logic expQ[$];

  tap_controller #(.IDCODE_VALUE(ID_VALUE)) dut (
    .TCK(TCK), .Reset(Reset), .TMS(TMS), .TDI(TDI), .BSC_TDO(BSC_TDO),
    .TDO(TDO), .TDO_En(TDO_En), .ShiftDR(ShiftDR), .ClockDR(ClockDR),
    .UpdateDR(UpdateDR), .Mode(Mode), .TapState(TapState)
  );

  // Free-running test clock
  always #5 TCK = ~TCK;

  // Count boundary-chain strobe pulses
  always @(posedge ClockDR) clockDrPulses++;
  always @(posedge UpdateDR) updateDrPulses++;

  // Hard stop if the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  // One TCK cycle; returns in the low half and scores TDO against the queue.
  task automatic applyStimulus(input logic tms, input logic tdi);
    logic expBit;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK); #1;
    @(negedge TCK); #1;
    if (TDO_En === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("tdoUnexpected", 32'(TDO_En), 32'd0);
      end else begin
        expBit = expQ.pop_front();
        checkOutput("tdo", 32'(TDO), 32'(expBit));
      end
    end else begin
      checkOutput("tdoIdle", 32'(TDO), 32'd0);
    end
  endtask

  task automatic stepState(input logic tms, input logic tdi, input logic [3:0] expState);
    applyStimulus(tms, tdi);
    checkOutput("state", 32'(TapState), 32'(expState));
  endtask

  task automatic doReset();
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    Reset = 1'b0;
    checkOutput("rstState", 32'(TapState), 32'hF);
    checkOutput("rstMode", 32'(Mode), 32'd0);
    checkOutput("rstShiftDr", 32'(ShiftDR), 32'd0);
    checkOutput("rstClockDr", 32'(ClockDR), 32'd0);
    checkOutput("rstUpdateDr", 32'(UpdateDR), 32'd0);
    checkOutput("rstTdoEn", 32'(TDO_En), 32'd0);
  endtask

  // Load an instruction starting and ending in Run-Test/Idle.
  task automatic irScan(input logic [3:0] code, input logic modeBefore, input logic modeAfter);
    stepState(1'b1, 1'b0, 4'h7);
    stepState(1'b1, 1'b0, 4'h4);
    expQ.push_back(1'b1);
    expQ.push_back(1'b0);
    expQ.push_back(1'b0);
    expQ.push_back(1'b0);
    stepState(1'b0, 1'b0, 4'hE);
    stepState(1'b0, 1'b0, 4'hA);
    stepState(1'b0, code[0], 4'hA);
    stepState(1'b0, code[1], 4'hA);
    stepState(1'b0, code[2], 4'hA);
    stepState(1'b1, code[3], 4'h9);
    checkOutput("modeShift", 32'(Mode), 32'(modeBefore));
    stepState(1'b1, 1'b0, 4'hD);
    checkOutput("modeHold", 32'(Mode), 32'(modeBefore));
    stepState(1'b0, 1'b0, 4'hC);
    checkOutput("modeUpdate", 32'(Mode), 32'(modeAfter));
    checkOutput("sbDrainIr", 32'(expQ.size()), 32'd0);
  endtask

  // Scan n DR bits from RTI back to RTI; expected TDO bits are queued by the caller.
  task automatic drScan(input int n, input logic [63:0] tdiBits, input logic [63:0] bscBits,
                        input logic bsc);
    int c0;
    int u0;
    c0 = clockDrPulses;
    u0 = updateDrPulses;
    stepState(1'b1, 1'b0, 4'h7);
    stepState(1'b0, 1'b0, 4'h6);
    checkOutput("shiftDrCap", 32'(ShiftDR), 32'd0);
    checkOutput("clockDrCap", 32'(ClockDR), 32'(bsc));
    BSC_TDO = bscBits[0];
    stepState(1'b0, 1'b0, 4'h2);
    checkOutput("shiftDr", 32'(ShiftDR), 32'(bsc));
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) begin
        BSC_TDO = bscBits[i+1];
        stepState(1'b0, tdiBits[i], 4'h2);
        checkOutput("shiftDr", 32'(ShiftDR), 32'(bsc));
      end else begin
        stepState(1'b1, tdiBits[i], 4'h1);
      end
    end
    stepState(1'b1, 1'b0, 4'h5);
    checkOutput("updateDr", 32'(UpdateDR), 32'(bsc));
    checkOutput("clockDrUpd", 32'(ClockDR), 32'd0);
    stepState(1'b0, 1'b0, 4'hC);
    checkOutput("updateDrIdle", 32'(UpdateDR), 32'd0);
    checkOutput("clockDrCount", 32'(clockDrPulses - c0), 32'(bsc ? n + 1 : 0));
    checkOutput("updateDrCount", 32'(updateDrPulses - u0), 32'(bsc ? 1 : 0));
    checkOutput("sbDrainDr", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [63:0] bscPat;
    logic [31:0] tdiPat;

    $display("[TB] reset");
    doReset();

    $display("[TB] walk to Pause-IR then TMS=1 x5");
    stepState(1'b0, 1'b0, 4'hC);
    stepState(1'b1, 1'b0, 4'h7);
    stepState(1'b1, 1'b0, 4'h4);
    stepState(1'b0, 1'b0, 4'hE);
    stepState(1'b1, 1'b0, 4'h9);
    stepState(1'b0, 1'b0, 4'hB);
    stepState(1'b1, 1'b0, 4'h8);
    stepState(1'b1, 1'b0, 4'hD);
    stepState(1'b1, 1'b0, 4'h7);
    stepState(1'b1, 1'b0, 4'h4);
    stepState(1'b1, 1'b0, 4'hF);
    checkOutput("tlrMode", 32'(Mode), 32'd0);
    stepState(1'b0, 1'b0, 4'hC);

    $display("[TB] EXTEST instruction and 51-bit boundary scan");
    irScan(4'b0000, 1'b0, 1'b1);
    bscPat = 64'h0005_A3C6_9E1B_7D24;
    for (int i = 0; i < 51; i++) expQ.push_back(bscPat[i]);
    drScan(51, 64'h1234_5678_9ABC_DEF0, bscPat, 1'b1);
    checkOutput("modeExtest", 32'(Mode), 32'd1);

    $display("[TB] BYPASS instruction and 4-bit scan");
    irScan(4'b1111, 1'b1, 1'b0);
    expQ.push_back(1'b0);
    expQ.push_back(1'b1);
    expQ.push_back(1'b0);
    expQ.push_back(1'b1);
    drScan(4, 64'hD, 64'h0, 1'b0);

    $display("[TB] reset then 32-bit DR scan");
    doReset();
    stepState(1'b0, 1'b0, 4'hC);
    tdiPat = 32'hA5C3_1E69;
`ifdef TAP_IDCODE_EN
    for (int i = 0; i < 32; i++) expQ.push_back(ID_VALUE[i]);
`else
    expQ.push_back(1'b0);
    for (int i = 0; i < 31; i++) expQ.push_back(tdiPat[i]);
`endif
    drScan(32, {32'd0, tdiPat}, 64'h0, 1'b0);

    $display("[TB] TLR via TMS restores the reset instruction");
    irScan(4'b0000, 1'b0, 1'b1);
    stepState(1'b1, 1'b0, 4'h7);
    stepState(1'b1, 1'b0, 4'h4);
    stepState(1'b1, 1'b0, 4'hF);
    checkOutput("tlrModeClear", 32'(Mode), 32'd0);
    stepState(1'b0, 1'b0, 4'hC);

    $display("[TB] unassigned opcode decodes as BYPASS");
    irScan(4'b0110, 1'b0, 1'b0);
    expQ.push_back(1'b0);
    expQ.push_back(1'b1);
    expQ.push_back(1'b1);
    drScan(3, 64'h3, 64'h7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
